// File: rtl/led_strip_scheduler.sv
// Frame sequencer for the LED bar: walks each LED index through the external
// colour mixer and streams the registered pixels to a WS2812 serializer.
module led_strip_scheduler #(
  parameter int N            = 10,
  parameter int N_LEDS       = 16,
  parameter int LATCH_CYCLES = 2500,
  parameter int GRB_ORDER    = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] nivel,
  input  logic [N-1:0] mid_idx,
  input  logic [N-1:0] max_idx,
  output logic [N-1:0] mix_contador,
  output logic [N-1:0] mix_mid,
  output logic [N-1:0] mix_max,
  input  logic [23:0]  mix_cor,
  output logic [23:0]  pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         busy,
  output logic         frame_done
);

  localparam int            CW         = $clog2(LATCH_CYCLES + 1);
  localparam logic [N-1:0]  LAST_IDX   = N'(N_LEDS - 1);
  localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, LATCH, DONE} state_t;

  state_t        state, state_n;
  logic          armed;
  logic [N-1:0]  idx;
  logic [N-1:0]  nivel_q, mid_q, max_q;
  logic [23:0]   pix_q;
  logic [23:0]   colour;
  logic [CW-1:0] latch_cnt;
  logic          start_ok;
  logic          handshake;

  // armed marks the single cycle between accepting start and the first FETCH,
  // during which the mixer settles on the freshly latched mid/max points.
  assign start_ok  = (state == IDLE) && !armed && start;
  assign handshake = pix_valid && pix_ready;
  assign colour    = (GRB_ORDER != 0) ? {mix_cor[15:8], mix_cor[23:16], mix_cor[7:0]}
                                      : mix_cor;

  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_n unassigned (no latch).
    state_n = state;
    case (state)
      IDLE:    if (armed) state_n = FETCH;
      FETCH:   state_n = SEND;
      SEND:    if (pix_ready) state_n = (idx == LAST_IDX) ? LATCH : FETCH;
      LATCH:   if (latch_cnt == CW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      idx       <= '0;
      nivel_q   <= '0;
      mid_q     <= '0;
      max_q     <= '0;
      pix_q     <= '0;
      latch_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_n;
      armed <= start_ok;
      if (start_ok) begin
        nivel_q <= nivel;
        mid_q   <= mid_idx;
        max_q   <= max_idx;
        idx     <= '0;
      end
      if (state == FETCH) pix_q <= (idx < nivel_q) ? colour : 24'h000000;
      if (state == SEND && handshake) begin
        if (idx == LAST_IDX) latch_cnt <= LATCH_LOAD;
        else                 idx       <= idx + N'(1);
      end
      if (state == LATCH) latch_cnt <= latch_cnt - CW'(1);
      // Park the index at 0 so the mixer sees LED 0 while idle.
      if (state == DONE) idx <= '0;
    end
  end

  assign mix_contador = idx;
  assign mix_mid      = mid_q;
  assign mix_max      = max_q;
  assign pix_data     = pix_q;
  assign pix_valid    = (state == SEND);
  assign frame_done   = (state == DONE);
  assign busy         = (state != IDLE) || armed;

endmodule
